// File: rtl/page_nav_pkg.sv
// page_nav_pkg: shared definitions for the OLED page navigation controller and
// the display mux that decodes its page code.
//   nav_state_e   - controller state encoding
//   PAGE_*        - page codes driven on page_nav.page
//   NUM_APPS      - number of selectable apps in the menu
//   app_page()    - page code of a given app index
package page_nav_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StWelcome,
        StMenu,
        StApp
    } nav_state_e;

    localparam logic [2:0] PAGE_LOAD     = 3'd0;
    localparam logic [2:0] PAGE_WELCOME  = 3'd1;
    localparam logic [2:0] PAGE_MENU     = 3'd2;
    localparam logic [2:0] PAGE_SOUNDBAR = 3'd3;
    localparam logic [2:0] PAGE_DFT      = 3'd4;
    localparam logic [2:0] PAGE_MAZE     = 3'd5;
    localparam logic [2:0] PAGE_GEODASH  = 3'd6;

    localparam int unsigned NUM_APPS = 4;

    // Apps occupy consecutive page codes starting at SOUNDBAR.
    function automatic logic [2:0] app_page(input logic [1:0] idx);
        return PAGE_SOUNDBAR + {1'b0, idx};
    endfunction

endpackage

// File: rtl/hold_detect.sv
// hold_detect: long-press detector for a debounced button level.
//   Parameter HOLD_CYCLES - consecutive high cycles that make a long press.
//   CLOCK       in  system clock
//   reset       in  synchronous active-high reset
//   enable      in  counting allowed (the owner's active state)
//   level       in  debounced button level
//   long_press  out one-cycle pulse on the cycle the hold completes
// After a long press the detector stays disarmed until level falls, so a
// button held past the threshold fires only once.
module hold_detect #(
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic enable,
    input  logic level,
    output logic long_press
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic             armed_q;

    // count_q holds the number of high cycles already seen, so the current
    // cycle is the HOLD_CYCLES-th one when count_q reaches CNT_LAST.
    assign long_press = enable && level && armed_q && (count_q == CNT_LAST);

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            count_q <= '0;
            armed_q <= 1'b1;
        end else if (!level) begin
            count_q <= '0;
            armed_q <= 1'b1;
        end else if (long_press) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (enable && armed_q) begin
            if (count_q != '1) begin
                count_q <= count_q + 1'b1;
            end
        end else begin
            count_q <= '0;
        end
    end

endmodule

// File: rtl/page_nav.sv
// page_nav: button-driven page navigation for the 96x64 OLED front end.
// Flow: LOAD -> WELCOME -> MENU (cursor over four apps) -> APP; a long centre
// press in APP returns to MENU.
//   CLOCK, reset                        clock, synchronous active-high reset
//   load_done                           loading animation finished (level)
//   btn_u/d/l/r/c                       debounced one-cycle button pulses
//   btn_c_level                         debounced centre-button level
//   page                                registered page code (page_nav_pkg)
//   cursor                              highlighted menu entry
//   app_en                              one-hot enable of the running app
//   app_u/d/l/r/c                       button pulses forwarded to the app
// Optional macro PAGE_NAV_TIMEOUT_EN: MENU falls back to WELCOME after
// TIMEOUT_CYCLES cycles without a button pulse.
module page_nav
    import page_nav_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100_000_000
`ifdef PAGE_NAV_TIMEOUT_EN
    ,
    parameter longint unsigned TIMEOUT_CYCLES = 64'd3_000_000_000
`endif
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic       load_done,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_c,
    input  logic       btn_c_level,
    output logic [2:0] page,
    output logic [1:0] cursor,
    output logic [3:0] app_en,
    output logic       app_u,
    output logic       app_d,
    output logic       app_l,
    output logic       app_r,
    output logic       app_c
);

    nav_state_e state_q;
    logic       long_press;
    logic       any_btn;

    assign any_btn = btn_u | btn_d | btn_l | btn_r | btn_c;

    hold_detect #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_detect (
        .CLOCK      (CLOCK),
        .reset      (reset),
        .enable     (state_q == StApp),
        .level      (btn_c_level),
        .long_press (long_press)
    );

`ifdef PAGE_NAV_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] idle_q;
`endif

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state_q <= StLoad;
            page    <= PAGE_LOAD;
            cursor  <= 2'd0;
            app_en  <= 4'd0;
            app_u   <= 1'b0;
            app_d   <= 1'b0;
            app_l   <= 1'b0;
            app_r   <= 1'b0;
            app_c   <= 1'b0;
`ifdef PAGE_NAV_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            // Forwarded pulses last one cycle unless APP re-registers them.
            app_u <= 1'b0;
            app_d <= 1'b0;
            app_l <= 1'b0;
            app_r <= 1'b0;
            app_c <= 1'b0;
`ifdef PAGE_NAV_TIMEOUT_EN
            idle_q <= '0;
`endif
            case (state_q)
                StLoad: begin
                    if (load_done) begin
                        state_q <= StWelcome;
                        page    <= PAGE_WELCOME;
                    end
                end
                StWelcome: begin
                    if (any_btn) begin
                        state_q <= StMenu;
                        page    <= PAGE_MENU;
                    end
                end
                StMenu: begin
                    // Centre wins over up/down; entry pulse is not forwarded.
                    if (btn_c) begin
                        state_q <= StApp;
                        page    <= app_page(cursor);
                        app_en  <= 4'b0001 << cursor;
                    end else if (btn_u && !btn_d) begin
                        cursor <= cursor - 2'd1;
                    end else if (btn_d && !btn_u) begin
                        cursor <= cursor + 2'd1;
                    end
`ifdef PAGE_NAV_TIMEOUT_EN
                    // A pulse on the expiry cycle keeps us in MENU.
                    if (!any_btn) begin
                        if (idle_q == TO_LAST) begin
                            state_q <= StWelcome;
                            page    <= PAGE_WELCOME;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
`endif
                end
                StApp: begin
                    if (long_press) begin
                        state_q <= StMenu;
                        page    <= PAGE_MENU;
                        app_en  <= 4'd0;
                    end else begin
                        app_u <= btn_u;
                        app_d <= btn_d;
                        app_l <= btn_l;
                        app_r <= btn_r;
                        app_c <= btn_c;
                    end
                end
                default: begin
                    state_q <= StLoad;
                    page    <= PAGE_LOAD;
                    app_en  <= 4'd0;
                end
            endcase
        end
    end

endmodule
